// File: rtl/fifo_status.sv
// fifo_status: single-clock FIFO with occupancy count, almost-full/almost-empty flags
// and sticky overflow/underflow. Define FIFO_STATUS_FWFT_EN for first-word-fall-through reads.
module fifo_status #(
    parameter int Word_Length       = 16,
    parameter int Depth_Of_FIFO     = 8,
    parameter int NBITS_FOR_COUNTER = $clog2(Depth_Of_FIFO + 1),
    parameter int AFULL_THRESH      = 6,
    parameter int AEMPTY_THRESH     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [Word_Length-1:0]       DataInput,
    input  logic                         pop,
    input  logic                         clear_errors,
    output logic [Word_Length-1:0]       DataOutput,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [NBITS_FOR_COUNTER-1:0] count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = (Depth_Of_FIFO > 1) ? $clog2(Depth_Of_FIFO) : 1;
    localparam logic [PTR_W-1:0]             LAST_PTR = PTR_W'(Depth_Of_FIFO - 1);
    localparam logic [NBITS_FOR_COUNTER-1:0] DEPTH_C  = NBITS_FOR_COUNTER'(Depth_Of_FIFO);
    localparam logic [NBITS_FOR_COUNTER-1:0] AFULL_C  = NBITS_FOR_COUNTER'(AFULL_THRESH);
    localparam logic [NBITS_FOR_COUNTER-1:0] AEMPTY_C = NBITS_FOR_COUNTER'(AEMPTY_THRESH);

    logic [Word_Length-1:0] mem [Depth_Of_FIFO];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   pop_ok;
    logic                   push_ok;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)
                count <= count + NBITS_FOR_COUNTER'(1);
            else if (pop_ok && !push_ok)
                count <= count - NBITS_FOR_COUNTER'(1);
        end
    end

    // A new error in the same cycle as clear_errors keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok)
                overflow <= 1'b1;
            else if (clear_errors)
                overflow <= 1'b0;
            if (pop && empty)
                underflow <= 1'b1;
            else if (clear_errors)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= DataInput;
    end

`ifdef FIFO_STATUS_FWFT_EN
    assign DataOutput = empty ? '0 : mem[rd_ptr];
`else
    logic [Word_Length-1:0] dout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            dout_q <= '0;
        else if (pop_ok)
            dout_q <= mem[rd_ptr];
    end

    assign DataOutput = dout_q;
`endif

endmodule

// File: tb/tb_fifo_status.sv
// tb_fifo_status: table-driven fill/drain vectors plus queue scoreboard for
// fifo_status read data, count, flags and sticky errors.
module tb_fifo_status;

    localparam int W      = 16;
    localparam int DEPTH  = 8;
    localparam int NB     = $clog2(DEPTH + 1);
    localparam int AFULL  = 6;
    localparam int AEMPTY = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [W-1:0]  DataInput;
    logic          pop;
    logic          clear_errors;
    logic [W-1:0]  DataOutput;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [NB-1:0] count;
    logic          overflow;
    logic          underflow;

    fifo_status #(
        .Word_Length      (W),
        .Depth_Of_FIFO    (DEPTH),
        .NBITS_FOR_COUNTER(NB),
        .AFULL_THRESH     (AFULL),
        .AEMPTY_THRESH    (AEMPTY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .DataInput   (DataInput),
        .pop         (pop),
        .clear_errors(clear_errors),
        .DataOutput  (DataOutput),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           p;
        logic [W-1:0] d;
        bit           q;
        bit           c;
        int           exp_count;
        bit           exp_ovf;
        bit           exp_unf;
    } vec_t;

    vec_t         tbl[18];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] mq[$];      // model FIFO contents
    logic [W-1:0] exp_rd[$];  // words expected to appear on DataOutput
    logic [W-1:0] last_dout;
    bit           m_ovf;
    bit           m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_rd.delete();
        last_dout = '0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
    endtask

    task automatic check_outputs();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AFULL));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_STATUS_FWFT_EN
        exp_rd.delete();
        chk("dout_fwft", 32'(DataOutput), (n > 0) ? 32'(mq[0]) : 32'd0);
`else
        if (exp_rd.size() > 0)
            last_dout = exp_rd.pop_front();
        chk("dout", 32'(DataOutput), 32'(last_dout));
`endif
    endtask

    // Drive one cycle of stimulus, predict its effect, then sample after the edge.
    task automatic step(input bit p, input logic [W-1:0] d, input bit q, input bit c);
        bit e_m, f_m, pop_ok, push_ok;
        e_m     = (mq.size() == 0);
        f_m     = (mq.size() == DEPTH);
        pop_ok  = q && !e_m;
        push_ok = p && (!f_m || pop_ok);
        push = p; DataInput = d; pop = q; clear_errors = c;
        if (pop_ok)  exp_rd.push_back(mq.pop_front());
        if (push_ok) mq.push_back(d);
        if (p && !push_ok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (q && e_m)      m_unf = 1'b1; else if (c) m_unf = 1'b0;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear_errors = 1'b0; DataInput = '0;
        check_outputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i]     = '{p: 1'b1, d: W'(8 - i), q: 1'b0, c: 1'b0,
                           exp_count: i + 1, exp_ovf: 1'b0, exp_unf: 1'b0};
            tbl[9 + i] = '{p: 1'b0, d: '0, q: 1'b1, c: 1'b0,
                           exp_count: 7 - i, exp_ovf: 1'b1, exp_unf: 1'b0};
        end
        tbl[8]  = '{p: 1'b1, d: 16'hAAAA, q: 1'b0, c: 1'b0, exp_count: 8, exp_ovf: 1'b1, exp_unf: 1'b0};
        tbl[17] = '{p: 1'b0, d: '0, q: 1'b1, c: 1'b0, exp_count: 0, exp_ovf: 1'b1, exp_unf: 1'b1};

        reset = 1'b0; push = 1'b0; pop = 1'b0; clear_errors = 1'b0; DataInput = '0;
        model_reset();
        #2;
        check_outputs();
        #10;
        reset = 1'b1;

        // Fill past full, then drain past empty.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].p, tbl[i].d, tbl[i].q, tbl[i].c);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_unf", i), 32'(underflow), 32'(tbl[i].exp_unf));
        end

        // Push and pop together on a full FIFO.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, W'(8 - i), 1'b0, 1'b0);
        step(1'b1, 16'h0009, 1'b1, 1'b0);
        chk("full_pushpop_count", 32'(count), 32'd8);
        chk("full_pushpop_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
`ifndef FIFO_STATUS_FWFT_EN
        chk("drain_last_word", 32'(DataOutput), 32'h0009);
`endif

        // Alternating push/pop walks the pointers around the wrap point.
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("alt_no_ovf", 32'(overflow), 32'd0);
        chk("alt_no_unf", 32'(underflow), 32'd0);

        // Asynchronous reset in mid-cycle with five entries held.
        for (int i = 0; i < 5; i++) step(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("midreset_count", 32'(count), 32'd0);
        chk("midreset_empty", 32'(empty), 32'd1);
        check_outputs();
        #2;
        reset = 1'b1;
        #4;

        // Overflow clearing, and a new error winning over clear_errors.
        for (int i = 0; i < 8; i++) step(1'b1, W'(16'h0200 + i), 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        step(1'b1, 16'hCAFE, 1'b0, 1'b1);
        chk("ovf_clear_vs_new", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
